// File: rtl/aes256_pkg.sv
// Shared types, constants and GF(2^8) helper for the AES MixColumns engine.
package aes256_pkg;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;
   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  col_t;
   typedef logic [7:0]   byte_t;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} fsm_e;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes256_mixcolumns_seq_if.sv
// Handshake bus between the MixColumns engine and its producer/consumer.
interface aes256_mixcolumns_seq_if;
   import aes256_pkg::*;

   logic   valid_i;
   logic   ready_o;
   logic   mode_i;
   state_t state_i;
   logic   valid_o;
   logic   ready_i;
   state_t state_o;
   logic   busy_o;

   modport slave  (input  valid_i, mode_i, state_i, ready_i,
                   output ready_o, valid_o, state_o, busy_o);
   modport master (output valid_i, mode_i, state_i, ready_i,
                   input  ready_o, valid_o, state_o, busy_o);
endinterface

// File: rtl/aes256_mixcolumn_col.sv
// Single-column MixColumns / InvMixColumns, purely combinational.
module aes256_mixcolumn_col
   import aes256_pkg::*;
(
   input  logic mode_i,
   input  col_t col_i,
   output col_t col_o
);

   byte_t w_a  [4];
   byte_t w_x2 [4];
   byte_t w_x4 [4];
   byte_t w_x8 [4];
   byte_t w_p0 [4];   // coefficient on own byte: 02 / 0E
   byte_t w_p1 [4];   // next byte: 03 / 0B
   byte_t w_p2 [4];   // byte +2: 01 / 0D
   byte_t w_p3 [4];   // byte +3: 01 / 09

   // Build per-byte multiples, then sum the rotated matrix row per output byte.
   always_comb begin
      col_o = '0;
      for (int i = 0; i < 4; i++) begin
         w_a[i]  = col_i[31-8*i -: 8];
         w_x2[i] = xtime(w_a[i]);
         w_x4[i] = xtime(w_x2[i]);
         w_x8[i] = xtime(w_x4[i]);
         if (mode_i == MODE_ENC) begin
            w_p0[i] = w_x2[i];
            w_p1[i] = w_x2[i] ^ w_a[i];
            w_p2[i] = w_a[i];
            w_p3[i] = w_a[i];
         end else begin
            w_p0[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
            w_p1[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
            w_p2[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
            w_p3[i] = w_x8[i] ^ w_a[i];
         end
      end
      for (int i = 0; i < 4; i++) begin
         col_o[31-8*i -: 8] = w_p0[i] ^ w_p1[(i+1)%4] ^ w_p2[(i+2)%4] ^ w_p3[(i+3)%4];
      end
   end

endmodule

// File: rtl/aes256_mixcolumns_seq.sv
// Column-serial MixColumns/InvMixColumns engine with valid/ready on both sides.
module aes256_mixcolumns_seq
   import aes256_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   aes256_mixcolumns_seq_if.slave   bus
);

   localparam int         NCYC = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST = 2'(NCYC - 1);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("aes256_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   fsm_e       r_fsm;
   logic [1:0] r_cnt;
   logic       r_mode;
   state_t     r_in;
   col_t       r_res [4];

   col_t       w_in_col [4];
   col_t       w_cin    [COLS_PER_CYCLE];
   col_t       w_cout   [COLS_PER_CYCLE];
   logic [1:0] w_idx    [COLS_PER_CYCLE];

   for (genvar c = 0; c < 4; c++) begin : g_split
      assign w_in_col[c] = r_in[127-32*c -: 32];
   end

   // One mixer lane per column handled in a cycle; lane g works on column cnt*CPC+g.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
      assign w_idx[g] = 2'(int'(r_cnt) * COLS_PER_CYCLE + g);
      assign w_cin[g] = w_in_col[w_idx[g]];
      aes256_mixcolumn_col u_col (
         .mode_i (r_mode),
         .col_i  (w_cin[g]),
         .col_o  (w_cout[g])
      );
   end

   // Control: accept in IDLE, walk the columns in CALC, hold result in DONE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fsm  <= IDLE;
         r_cnt  <= '0;
         r_mode <= 1'b0;
         r_in   <= '0;
      end else begin
         case (r_fsm)
            IDLE: if (bus.valid_i) begin
               r_in   <= bus.state_i;
               r_mode <= bus.mode_i;
               r_cnt  <= '0;
               r_fsm  <= CALC;
            end
            CALC: if (r_cnt == LAST) begin
               r_cnt <= '0;
               r_fsm <= DONE;
            end else begin
               r_cnt <= r_cnt + 2'd1;
            end
            DONE: if (bus.ready_i) r_fsm <= IDLE;
            default: r_fsm <= IDLE;
         endcase
      end
   end

   // Datapath: write the columns produced this cycle into the result register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < 4; c++) r_res[c] <= '0;
      end else if (r_fsm == CALC) begin
         for (int g = 0; g < COLS_PER_CYCLE; g++) r_res[w_idx[g]] <= w_cout[g];
      end
   end

   // Outputs come only from registers and the state decode.
   assign bus.ready_o = (r_fsm == IDLE);
   assign bus.valid_o = (r_fsm == DONE);
   assign bus.busy_o  = (r_fsm != IDLE);
   assign bus.state_o = {r_res[0], r_res[1], r_res[2], r_res[3]};

endmodule

// File: tb/tb_aes256_mixcolumns_seq.sv
// Directed bench: vector table on all three column widths plus handshake corner cases.
module tb_aes256_mixcolumns_seq;
   import aes256_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] tb_valid = '0;
   logic [2:0] tb_ready = '0;
   logic       tb_mode  = 1'b0;
   state_t     tb_state = '0;

   logic [2:0]        o_valid, o_ready, o_busy;
   logic [2:0][127:0] o_state;

   aes256_mixcolumns_seq_if if1 ();
   aes256_mixcolumns_seq_if if2 ();
   aes256_mixcolumns_seq_if if4 ();

   assign if1.valid_i = tb_valid[0];
   assign if2.valid_i = tb_valid[1];
   assign if4.valid_i = tb_valid[2];
   assign if1.ready_i = tb_ready[0];
   assign if2.ready_i = tb_ready[1];
   assign if4.ready_i = tb_ready[2];
   assign if1.mode_i = tb_mode;   assign if2.mode_i = tb_mode;   assign if4.mode_i = tb_mode;
   assign if1.state_i = tb_state; assign if2.state_i = tb_state; assign if4.state_i = tb_state;

   assign o_valid = {if4.valid_o, if2.valid_o, if1.valid_o};
   assign o_ready = {if4.ready_o, if2.ready_o, if1.ready_o};
   assign o_busy  = {if4.busy_o,  if2.busy_o,  if1.busy_o};
   assign o_state = {if4.state_o, if2.state_o, if1.state_o};

   aes256_mixcolumns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
   aes256_mixcolumns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));
   aes256_mixcolumns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(if4));

   int n_tests = 0;
   int n_fail  = 0;
   int ncyc [3] = '{4, 2, 1};

   typedef struct {
      logic   mode;
      state_t din;
      state_t dout;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s ready k%0d", nm, k), 128'(o_ready[k]), 128'd1);
         chk($sformatf("%s valid k%0d", nm, k), 128'(o_valid[k]), 128'd0);
         chk($sformatf("%s busy k%0d", nm, k),  128'(o_busy[k]),  128'd0);
         chk($sformatf("%s state k%0d", nm, k), o_state[k], 128'd0);
      end
   endtask

   // Offer one block, flip mode after the accept edge, count cycles to valid_o.
   task automatic send(input int k, input logic m, input state_t s, output int lat);
      int n;
      @(posedge clk); #1;
      tb_mode = m; tb_state = s; tb_valid[k] = 1'b1;
      n = 0;
      while (!o_ready[k] && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      tb_valid[k] = 1'b0;
      tb_mode = ~m;
      tb_state = ~s;
      lat = 0;
      while (!o_valid[k] && lat < 20) begin @(posedge clk); #1; lat++; end
      if (!o_valid[k]) lat = -1;
   endtask

   task automatic release_blk(input int k, input string nm);
      tb_ready[k] = 1'b1;
      @(posedge clk); #1;
      tb_ready[k] = 1'b0;
      chk({nm, " valid drop"}, 128'(o_valid[k]), 128'd0);
      chk({nm, " ready back"}, 128'(o_ready[k]), 128'd1);
   endtask

   task automatic run_block(input int k, input logic m, input state_t s, input state_t e, input string nm);
      int lat;
      send(k, m, s, lat);
      chk({nm, " latency"}, 128'(lat), 128'(ncyc[k]));
      chk({nm, " result"}, o_state[k], e);
      chk({nm, " ready low"}, 128'(o_ready[k]), 128'd0);
      release_blk(k, nm);
   endtask

   localparam state_t FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam state_t FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

   initial begin
      int lat;
      state_t held;
      int t_first, t_second, cyc;
      logic prev;

      vecs[0] = '{MODE_ENC, FIPS_IN, FIPS_OUT};
      vecs[1] = '{MODE_DEC, FIPS_OUT, FIPS_IN};
      vecs[2] = '{MODE_ENC, {4{32'hdb135345}}, {4{32'h8e4da1bc}}};
      vecs[3] = '{MODE_DEC, {4{32'h8e4da1bc}}, {4{32'hdb135345}}};
      vecs[4] = '{MODE_ENC, 128'hdb135345_f20a225c_01010101_2d26314c,
                            128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8};
      vecs[5] = '{MODE_DEC, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8,
                            128'hdb135345_f20a225c_01010101_2d26314c};
      vecs[6] = '{MODE_ENC, 128'hd4d4d4d5_c6c6c6c6_00000000_f20a225c,
                            128'hd5d5d7d6_c6c6c6c6_00000000_9fdc589d};
      vecs[7] = '{MODE_DEC, 128'hd5d5d7d6_c6c6c6c6_00000000_9fdc589d,
                            128'hd4d4d4d5_c6c6c6c6_00000000_f20a225c};

      // Reset held, then released and idling.
      #1;
      chk_reset("rst held");
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk_reset("idle");

      // Vector table on every column width.
      for (int k = 0; k < 3; k++)
         for (int v = 0; v < 8; v++)
            run_block(k, vecs[v].mode, vecs[v].din, vecs[v].dout, $sformatf("vec%0d k%0d", v, k));

      // Backpressure: hold DONE, poke valid_i, nothing may change.
      send(0, MODE_ENC, FIPS_IN, lat);
      chk("bp latency", 128'(lat), 128'd4);
      held = o_state[0];
      chk("bp result", held, FIPS_OUT);
      for (int c = 0; c < 10; c++) begin
         tb_valid[0] = c[0];
         tb_state = {4{$urandom}};
         tb_mode = $urandom_range(0, 1);
         @(posedge clk); #1;
         chk($sformatf("bp valid c%0d", c), 128'(o_valid[0]), 128'd1);
         chk($sformatf("bp ready c%0d", c), 128'(o_ready[0]), 128'd0);
         chk($sformatf("bp state c%0d", c), o_state[0], FIPS_OUT);
      end
      tb_valid[0] = 1'b0;
      release_blk(0, "bp");
      repeat (3) @(posedge clk);
      #1;
      chk("bp no second capture", 128'(o_busy[0]), 128'd0);
      run_block(0, vecs[4].mode, vecs[4].din, vecs[4].dout, "bp next");

      // Reset in the middle of CALC at column count 2.
      @(posedge clk); #1;
      tb_mode = MODE_ENC; tb_state = FIPS_IN; tb_valid[0] = 1'b1;
      @(posedge clk); #1;
      tb_valid[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid busy", 128'(o_busy[0]), 128'd1);
      rst_n = 1'b0;
      #1;
      chk_reset("mid rst");
      @(negedge clk); rst_n = 1'b1;
      run_block(0, MODE_ENC, '0, '0, "zero enc");
      run_block(0, MODE_DEC, '0, '0, "zero dec");
      run_block(0, MODE_ENC, {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, "c6 enc");
      run_block(0, MODE_DEC, {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, "c6 dec");

      // Back-to-back with valid_i and ready_i tied high: interval NCYC+2.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         tb_mode = MODE_ENC; tb_state = FIPS_IN;
         tb_valid[k] = 1'b1; tb_ready[k] = 1'b1;
         t_first = -1; t_second = -1; prev = 1'b0;
         cyc = 0;
         while (t_second < 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (o_valid[k] && !prev) begin
               chk($sformatf("b2b result k%0d", k), o_state[k], FIPS_OUT);
               if (t_first < 0) t_first = cyc; else t_second = cyc;
            end
            prev = o_valid[k];
         end
         tb_valid[k] = 1'b0;
         cyc = 0;
         while (o_busy[k] && cyc < 20) begin @(posedge clk); #1; cyc++; end
         tb_ready[k] = 1'b0;
         chk($sformatf("b2b drained k%0d", k), 128'(o_busy[k]), 128'd0);
         chk($sformatf("b2b interval k%0d", k), 128'(t_second - t_first), 128'(ncyc[k] + 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
